// File: rtl/uart_pkg.sv
// Shared UART constants: frame layout, parity and baud codes, TX state encoding.
// The receive side imports the same package so both ends agree on the frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int FRAME_W = 11;

  // Clocks per bit, rounded to nearest so 50 MHz / 4800 gives 10417.
  function automatic int unsigned baud_div(
    input int unsigned clk_freq,
    input int unsigned rate
  );
    return (clk_freq + rate / 2) / rate;
  endfunction

  function automatic logic par_bit(
    input logic [7:0] d,
    input logic [1:0] pt
  );
    logic p;
    unique case (pt)
      PAR_ODD:  p = ~^d;
      PAR_EVEN: p = ^d;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period generator: divisor latched on clear, counter wraps at DIV-1.
// bit_tick_o marks the last clock of each bit period while enabled.
module uart_tx_baud
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] baud_i,
  output logic       bit_tick_o
);

  localparam int unsigned DIV_0 = baud_div(CLK_FREQ, 2400);
  localparam int unsigned DIV_1 = baud_div(CLK_FREQ, 4800);
  localparam int unsigned DIV_2 = baud_div(CLK_FREQ, 9600);
  localparam int unsigned DIV_3 = baud_div(CLK_FREQ, 19200);
  localparam int CNT_W = $clog2(DIV_0 + 1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = en_i && (cnt_q == div_q - 1'b1);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
      unique case (baud_i)
        BAUD_2400:  div_d = CNT_W'(DIV_0);
        BAUD_4800:  div_d = CNT_W'(DIV_1);
        BAUD_9600:  div_d = CNT_W'(DIV_2);
        default:    div_d = CNT_W'(DIV_3);
      endcase
    end else if (en_i) begin
      cnt_d = bit_tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: latches {stop, parity, data, start} on accept and
// shifts it out LSB-first, one bit per baud period.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               send,
  input  logic [7:0]         data_in,
  input  logic [1:0]         parity_type,
  input  logic [1:0]         baud_rate,
  output logic               data_tx,
  output logic               active_flag,
  output logic               done_flag,
  output logic [FRAME_W-1:0] tx_frame
);

  tx_state_t          state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               accept;
  logic               tick;
  logic [FRAME_W-1:0] frame_new;

  assign frame_new = {1'b1, par_bit(data_in, parity_type), data_in, 1'b0};

  uart_tx_baud #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr_i      (accept),
    .en_i       (active_q),
    .baud_i     (baud_rate),
    .bit_tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    frame_d  = frame_q;
    active_d = active_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    // Ones shift in behind the frame so the line rests high after stop.
    if (tick) shift_d = {1'b1, shift_q[FRAME_W-1:1]};
    unique case (state_q)
      IDLE: begin
        if (send) begin
          accept   = 1'b1;
          frame_d  = frame_new;
          shift_d  = frame_new;
          active_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) state_d = PARITY;
          else idx_d = idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '1;
      frame_q  <= '1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign data_tx     = shift_q[0];
  assign active_flag = active_q;
  assign done_flag   = done_q;
  assign tx_frame    = frame_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: scoreboard of expected frames, decoded
// from the serial line at bit centres with a small receiver model.
module tb_uart_tx_unit;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 96_000;

  typedef struct {
    logic [10:0] frame;
    logic [7:0]  data;
    logic [1:0]  par;
    int          div;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        send = 1'b0;
  logic [7:0]  data_in = '0;
  logic [1:0]  parity_type = '0;
  logic [1:0]  baud_rate = '0;
  logic        data_tx;
  logic        active_flag;
  logic        done_flag;
  logic [10:0] tx_frame;

  always #5 clock = ~clock;

  uart_tx_unit #(
    .CLK_FREQ (CLK_FREQ)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .tx_frame    (tx_frame)
  );

  function automatic int exp_div(input logic [1:0] b);
    case (b)
      2'b00:   return 40;
      2'b01:   return 20;
      2'b10:   return 10;
      default: return 5;
    endcase
  endfunction

  function automatic logic exp_par(input logic [7:0] d, input logic [1:0] p);
    case (p)
      2'b01:   return ~^d;
      2'b10:   return ^d;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] p,
                          input logic [1:0] b);
    exp_t e;
    e.data  = d;
    e.par   = p;
    e.div   = exp_div(b);
    e.frame = {1'b1, exp_par(d, p), d, 1'b0};
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [1:0] p,
                           input logic [1:0] b, input bit hold);
    @(negedge clock);
    send = 1'b1;
    data_in = d;
    parity_type = p;
    baud_rate = b;
    push_exp(d, p, b);
    @(negedge clock);
    chk("accept_line", data_tx, 0);
    chk("accept_active", active_flag, 1);
    if (!hold) send = 1'b0;
  endtask

  // Ends on the negedge where done_flag must be high.
  task automatic capture(input string tag, input bit disturb);
    exp_t e;
    logic [10:0] rx;
    logic [2:0] err;
    int n = 0;
    while (data_tx !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_start_seen"}, data_tx, 0);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    repeat (e.div / 2) @(negedge clock);
    for (int k = 0; k < 11; k++) begin
      rx[k] = data_tx;
      if (disturb && k == 4) begin
        data_in = ~data_in;
        baud_rate = baud_rate + 2'd1;
        parity_type = parity_type ^ 2'b11;
        send = 1'b1;
      end
      if (disturb && k == 5) send = 1'b0;
      if (k < 10) repeat (e.div) @(negedge clock);
    end
    chk({tag, "_tx_frame"}, tx_frame, e.frame);
    chk({tag, "_line_frame"}, rx, e.frame);
    chk({tag, "_rx_data"}, rx[8:1], e.data);
    err = {rx[10] !== 1'b1, rx[9] !== exp_par(rx[8:1], e.par), rx[0] !== 1'b0};
    chk({tag, "_rx_err"}, err, 0);
    repeat (e.div - e.div / 2 - 1) @(negedge clock);
    chk({tag, "_done_early"}, done_flag, 0);
    chk({tag, "_active_last"}, active_flag, 1);
    @(negedge clock);
    chk({tag, "_done_pulse"}, done_flag, 1);
    chk({tag, "_active_end"}, active_flag, 0);
    chk({tag, "_line_idle"}, data_tx, 1);
  endtask

  initial begin
    exp_t drop;
    int extra;
    int dn;
    logic [7:0] rnd;

    repeat (3) @(negedge clock);
    chk("rst_line", data_tx, 1);
    chk("rst_active", active_flag, 0);
    chk("rst_done", done_flag, 0);
    chk("rst_frame", tx_frame, 11'h7FF);
    reset_n = 1'b1;
    @(negedge clock);

    send_byte(8'hA5, 2'b10, 2'b10, 1'b0);
    capture("t1_even", 1'b0);
    @(negedge clock);
    chk("t1_pulse_width", done_flag, 0);

    send_byte(8'hA5, 2'b01, 2'b10, 1'b0);
    capture("t2_odd", 1'b0);
    send_byte(8'hA5, 2'b00, 2'b10, 1'b0);
    capture("t2_none", 1'b0);
    chk("t2_none_const", tx_frame, 11'b1_1_10100101_0);

    send_byte(8'h00, 2'b10, 2'b11, 1'b1);
    data_in = 8'hFF;
    push_exp(8'hFF, 2'b10, 2'b11);
    capture("t3a", 1'b0);
    @(negedge clock);
    chk("t3_gap_done", done_flag, 0);
    chk("t3_gap_line", data_tx, 0);
    send = 1'b0;
    capture("t3b", 1'b0);

    send_byte(8'h3C, 2'b01, 2'b01, 1'b0);
    capture("t4", 1'b1);
    extra = 0;
    repeat (120) begin
      @(negedge clock);
      if (active_flag !== 1'b0 || data_tx !== 1'b1) extra++;
    end
    chk("t4_no_extra", extra, 0);

    send_byte(8'h5A, 2'b10, 2'b10, 1'b0);
    repeat (25) @(negedge clock);
    chk("t5_mid_active", active_flag, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_line", data_tx, 1);
    chk("t5_async_active", active_flag, 0);
    drop = sb.pop_front();
    dn = 0;
    repeat (5) begin
      @(negedge clock);
      if (done_flag !== 1'b0) dn++;
    end
    chk("t5_no_done", dn, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_rst_frame", tx_frame, 11'h7FF);
    send_byte(8'hC3, 2'b01, 2'b00, 1'b0);
    capture("t5_clean", 1'b0);

    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 4; p++) begin
        rnd = 8'($urandom);
        send_byte(rnd, 2'(p), 2'(b), 1'b0);
        capture("t6_loop", 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
